// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the MIPS core: registers decoded control, operands and
// instruction fields, with valid/hold/flush handling and a load-use hazard stall counter.
module id_ex_stage_reg #(
    parameter int LEN_DATA       = 32,
    parameter int NUM_BITS       = 5,
    parameter int LEN_EXEC_BUS   = 11,
    parameter int LEN_MEM_BUS    = 9,
    parameter int LEN_WB_BUS     = 2,
    parameter int MEM_READ_BIT   = 1,
    parameter int JUMP_BIT       = 5,
    parameter int JR_BIT         = 4,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [LEN_DATA-1:0]     in_pc_branch,
    input  logic [LEN_DATA-1:0]     in_instruccion,
    input  logic [LEN_DATA-1:0]     in_reg1,
    input  logic [LEN_DATA-1:0]     in_reg2,
    input  logic [LEN_EXEC_BUS-1:0] in_exec_bus,
    input  logic [LEN_MEM_BUS-1:0]  in_mem_bus,
    input  logic [LEN_WB_BUS-1:0]   in_wb_bus,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    halt_flag_d,
    output logic                    out_valid,
    output logic [LEN_DATA-1:0]     out_pc_branch,
    output logic [LEN_DATA-1:0]     out_reg1,
    output logic [LEN_DATA-1:0]     out_reg2,
    output logic [LEN_DATA-1:0]     out_sign_extend,
    output logic [NUM_BITS-1:0]     out_rs,
    output logic [NUM_BITS-1:0]     out_rt,
    output logic [NUM_BITS-1:0]     out_rd,
    output logic [NUM_BITS-1:0]     out_shamt,
    output logic [LEN_EXEC_BUS-1:0] execute_bus,
    output logic [LEN_MEM_BUS-1:0]  memory_bus,
    output logic [LEN_WB_BUS-1:0]   writeBack_bus,
    output logic                    out_halt_flag_d,
    output logic [LEN_DATA-1:0]     out_pc_jump,
    output logic                    flag_jump,
    output logic                    flag_jump_register,
    output logic                    stall_flag
);

    typedef struct packed {
        logic                    valid;
        logic [LEN_DATA-1:0]     pc_branch;
        logic [LEN_DATA-1:0]     reg1;
        logic [LEN_DATA-1:0]     reg2;
        logic [LEN_DATA-1:0]     sign_extend;
        logic [NUM_BITS-1:0]     rs;
        logic [NUM_BITS-1:0]     rt;
        logic [NUM_BITS-1:0]     rd;
        logic [NUM_BITS-1:0]     shamt;
        logic [LEN_EXEC_BUS-1:0] exec;
        logic [LEN_MEM_BUS-1:0]  mem;
        logic [LEN_WB_BUS-1:0]   wb;
    } stage_t;

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALL - 1);

    stage_t              r_stage;
    stage_t              w_stage_next;
    stage_t              w_load;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_next;
    logic                r_halt;
    logic [NUM_BITS-1:0] w_dec_rs;
    logic [NUM_BITS-1:0] w_dec_rt;
    logic                w_hazard;
    logic                w_cnt_busy;
    logic                w_stall;
    logic                w_jump_ok;
    logic                w_unused_opcode;

    assign w_dec_rs        = NUM_BITS'(in_instruccion[25:21]);
    assign w_dec_rt        = NUM_BITS'(in_instruccion[20:16]);
    assign w_unused_opcode = ^in_instruccion[31:26];

    always_comb begin
        w_load.valid       = in_valid;
        w_load.pc_branch   = in_pc_branch;
        w_load.reg1        = in_reg1;
        w_load.reg2        = in_reg2;
        w_load.sign_extend = {{(LEN_DATA-16){in_instruccion[15]}}, in_instruccion[15:0]};
        w_load.rs          = w_dec_rs;
        w_load.rt          = w_dec_rt;
        w_load.rd          = NUM_BITS'(in_instruccion[15:11]);
        w_load.shamt       = NUM_BITS'(in_instruccion[10:6]);
        w_load.exec        = in_exec_bus;
        w_load.mem         = in_mem_bus;
        w_load.wb          = in_wb_bus;
    end

    // A load in EX whose destination feeds the instruction now in decode; $0 never conflicts.
    assign w_hazard   = r_stage.valid & r_stage.mem[MEM_READ_BIT] & in_valid &
                        (r_stage.rt != '0) &
                        ((r_stage.rt == w_dec_rs) | (r_stage.rt == w_dec_rt));
    assign w_cnt_busy = (r_cnt != 3'd0);
    assign w_stall    = ~flush & (w_hazard | w_cnt_busy);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_stage_next = r_stage;
        w_cnt_next   = r_cnt;
        if (flush) begin
            w_stage_next = '0;
            w_cnt_next   = 3'd0;
        end else if (!hold) begin
            if (w_hazard && !w_cnt_busy) begin
                w_stage_next = '0;
                w_cnt_next   = STALL_RELOAD;
            end else if (w_cnt_busy) begin
                w_stage_next = '0;
                w_cnt_next   = r_cnt - 3'd1;
            end else begin
                w_stage_next = w_load;
            end
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage <= '0;
            r_cnt   <= 3'd0;
            r_halt  <= 1'b0;
        end else begin
            r_stage <= w_stage_next;
            r_cnt   <= w_cnt_next;
            r_halt  <= halt_flag_d;
        end
    end

    // Jump redirects are suppressed while the decode slot is squashed or stalled.
    assign w_jump_ok          = ~flush & ~w_stall;
    assign out_pc_jump        = w_jump_ok ?
                                {in_pc_branch[LEN_DATA-1:28], in_instruccion[25:0], 2'b00} : '0;
    assign flag_jump          = w_jump_ok & in_exec_bus[JUMP_BIT];
    assign flag_jump_register = w_jump_ok & in_exec_bus[JR_BIT];
    assign stall_flag         = w_stall;

    assign out_valid       = r_stage.valid;
    assign out_pc_branch   = r_stage.pc_branch;
    assign out_reg1        = r_stage.reg1;
    assign out_reg2        = r_stage.reg2;
    assign out_sign_extend = r_stage.sign_extend;
    assign out_rs          = r_stage.rs;
    assign out_rt          = r_stage.rt;
    assign out_rd          = r_stage.rd;
    assign out_shamt       = r_stage.shamt;
    assign execute_bus     = r_stage.exec;
    assign memory_bus      = r_stage.mem;
    assign writeBack_bus   = r_stage.wb;
    assign out_halt_flag_d = r_halt;

endmodule
